// File: rtl/kplic_arbiter.sv
// KPLIC arbitration stage: pending latch, priority select, claim/complete handling.
// Optional macro KPLIC_THRESHOLD_EN enables the hart priority threshold.
module kplic_arbiter #(
  parameter int INT_NUM = 8,
  parameter int ID_W    = 4,
  parameter int PRIO_W  = 3
) (
  input  logic                      kplic_clk,
  input  logic                      kplic_rstn,
  input  logic [INT_NUM-1:0]        valid_int_req,
  input  logic [INT_NUM-1:0]        int_enable,
  input  logic [INT_NUM*PRIO_W-1:0] int_priority,
  input  logic [PRIO_W-1:0]         int_threshold,
  input  logic                      claim_rd,
  output logic [ID_W-1:0]           claim_id,
  input  logic                      complete_wr,
  input  logic [ID_W-1:0]           complete_id,
  output logic [INT_NUM-1:0]        int_completion,
  output logic [INT_NUM-1:0]        int_pending,
  output logic                      ext_int_req
);

  logic [INT_NUM-1:0] pending;
  logic [INT_NUM-1:0] pend_nxt;
  logic [INT_NUM-1:0] eligible;
  logic [INT_NUM-1:0] comp_nxt;
  logic [ID_W-1:0]    best_id;
  logic [ID_W-1:0]    best_id_nxt;
  logic [PRIO_W-1:0]  best_prio;
  logic [PRIO_W-1:0]  best_prio_nxt;
  logic [PRIO_W-1:0]  thr;

`ifdef KPLIC_THRESHOLD_EN
  assign thr = int_threshold;
`else
  logic unused_threshold;
  assign unused_threshold = ^int_threshold;
  assign thr = '0;
`endif

  // best_prio is kept as a flop for debug visibility; nothing downstream reads it.
  logic unused_best_prio;
  assign unused_best_prio = ^best_prio;

  // A new request wins over a claim of the same ID in the same cycle.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      pend_nxt[i] = valid_int_req[i] |
                    (pending[i] & ~(claim_rd & (best_id == ID_W'(i + 1))));
    end
  end

  assign eligible = pend_nxt & int_enable;

  // Strict greater-than keeps the lowest ID on ties; starting at 0 excludes priority 0.
  always_comb begin
    best_id_nxt   = '0;
    best_prio_nxt = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      if (eligible[i] && (int_priority[i*PRIO_W +: PRIO_W] > best_prio_nxt)) begin
        best_id_nxt   = ID_W'(i + 1);
        best_prio_nxt = int_priority[i*PRIO_W +: PRIO_W];
      end
    end
  end

  // Out-of-range IDs simply match no bit.
  always_comb begin
    comp_nxt = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      comp_nxt[i] = complete_wr & (complete_id == ID_W'(i + 1));
    end
  end

  always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
    if (!kplic_rstn) begin
      pending        <= '0;
      best_id        <= '0;
      best_prio      <= '0;
      ext_int_req    <= 1'b0;
      int_completion <= '0;
    end else begin
      pending        <= pend_nxt;
      best_id        <= best_id_nxt;
      best_prio      <= best_prio_nxt;
      ext_int_req    <= (best_prio_nxt > thr);
      int_completion <= comp_nxt;
    end
  end

  assign claim_id    = best_id;
  assign int_pending = pending;

endmodule
